// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// MULDIV_DIV_ZERO_TRAP_EN adds the TRAP state used for divide-by-zero.
package muldiv_pkg;

  localparam int MAX_CYCLES_DEF = 64;
  localparam int CNT_W_DEF      = 7;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_MULT  = 2'b00,
    SEL_DIV   = 2'b01,
    SEL_DIVU  = 2'b10,
    SEL_MULTU = 2'b11
  } hilo_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    ST_TRAP  = 3'd4,
`endif
    ST_WRITE = 3'd3
  } state_e;

  // HI/LO source select does not share the op_code numbering.
  function automatic hilo_sel_e op_to_sel(input op_e op);
    hilo_sel_e sel;
    case (op)
      OP_MULT:  sel = SEL_MULT;
      OP_MULTU: sel = SEL_MULTU;
      OP_DIV:   sel = SEL_DIV;
      OP_DIVU:  sel = SEL_DIVU;
      default:  sel = SEL_MULT;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-cycle counter for the sequencer: clear, increment, and flag the last
// permitted cycle (count == MAX_CYCLES-1).
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign expire_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues one MULT/MULTU/DIV/DIVU to the shared iterative unit, waits out its busy
// window under a watchdog, then writes HI/LO. MULDIV_DIV_ZERO_TRAP_EN enables div-by-zero trap.
//
// state | meaning
// IDLE  | ready for a new operation
// START | one-cycle start pulse for the latched op
// WAIT  | unit computing, watchdog counting
// WRITE | HI/LO write, done pulse
// TRAP  | divide-by-zero exception pulse (trap build only)
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_rs,
  input  logic [31:0] op_rt,
  output logic        op_ready,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mul_start,
  output logic        mulu_start,
  output logic        div_start,
  output logic        divu_start,
  input  logic        unit_busy,
  output logic        hi_ena,
  output logic        lo_ena,
  output logic [1:0]  hi_input_signal,
  output logic [1:0]  lo_input_signal,
  output logic        done,
  output logic        timeout,
`ifdef MULDIV_DIV_ZERO_TRAP_EN
  output logic        div_zero_exc,
`endif
  input  logic        hilo_read_req,
  output logic        hilo_read_stall
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic             wd_clr, wd_inc, wd_expire;
  logic [CNT_W-1:0] wd_cnt;

  muldiv_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .cnt_o    (wd_cnt),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_clr = 1'b1;
        if (op_valid) begin
          op_d    = op_e'(op_code);
          a_d     = op_rs;
          b_d     = op_rt;
          state_d = ST_START;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
          if (op_code[1] && (op_rt == 32'd0)) begin
            state_d = ST_TRAP;
          end
`endif
        end
      end
      ST_START: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_inc = 1'b1;
        // First WAIT cycle (count 0) ignores busy: the unit may raise it a cycle late.
        if (!unit_busy && (wd_cnt != '0)) begin
          state_d = ST_WRITE;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
      ST_TRAP:  state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign op_ready   = (state_q == ST_IDLE) && rst;
  assign unit_a     = a_q;
  assign unit_b     = b_q;

  assign mul_start  = (state_q == ST_START) && (op_q == OP_MULT);
  assign mulu_start = (state_q == ST_START) && (op_q == OP_MULTU);
  assign div_start  = (state_q == ST_START) && (op_q == OP_DIV);
  assign divu_start = (state_q == ST_START) && (op_q == OP_DIVU);

  assign hi_ena          = (state_q == ST_WRITE);
  assign lo_ena          = (state_q == ST_WRITE);
  assign hi_input_signal = op_to_sel(op_q);
  assign lo_input_signal = op_to_sel(op_q);
  assign done            = (state_q == ST_WRITE);

  // Fires in the last permitted WAIT cycle, the one that abandons the op.
  assign timeout = (state_q == ST_WAIT) && wd_expire && unit_busy;

`ifdef MULDIV_DIV_ZERO_TRAP_EN
  assign div_zero_exc = (state_q == ST_TRAP);
`endif

  assign hilo_read_stall = hilo_read_req && (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a simple busy-window unit model.
// Compile with the same MULDIV_DIV_ZERO_TRAP_EN setting as the RTL.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_rs = 32'd0;
  logic [31:0] op_rt = 32'd0;
  logic        unit_busy = 1'b0;
  logic        hilo_read_req = 1'b0;
  logic        op_ready, mul_start, mulu_start, div_start, divu_start;
  logic        hi_ena, lo_ena, done, timeout, hilo_read_stall;
  logic [31:0] unit_a, unit_b;
  logic [1:0]  hi_input_signal, lo_input_signal;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
  logic        div_zero_exc;
  logic        div_zero_exc_w;
`endif

  // Second instance with a short watchdog and a stuck-busy unit.
  logic        op_valid_w = 1'b0;
  logic        op_ready_w, mul_start_w, mulu_start_w, div_start_w, divu_start_w;
  logic        hi_ena_w, lo_ena_w, done_w, timeout_w, stall_w;
  logic [31:0] unit_a_w, unit_b_w;
  logic [1:0]  hi_sel_w, lo_sel_w;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_rs(op_rs), .op_rt(op_rt),
    .op_ready(op_ready), .unit_a(unit_a), .unit_b(unit_b),
    .mul_start(mul_start), .mulu_start(mulu_start), .div_start(div_start), .divu_start(divu_start),
    .unit_busy(unit_busy), .hi_ena(hi_ena), .lo_ena(lo_ena),
    .hi_input_signal(hi_input_signal), .lo_input_signal(lo_input_signal),
    .done(done), .timeout(timeout),
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    .div_zero_exc(div_zero_exc),
`endif
    .hilo_read_req(hilo_read_req), .hilo_read_stall(hilo_read_stall)
  );

  muldiv_sequencer #(.MAX_CYCLES(8), .CNT_W(4)) dut_wd (
    .clk(clk), .rst(rst), .op_valid(op_valid_w), .op_code(2'b00), .op_rs(32'd1), .op_rt(32'd2),
    .op_ready(op_ready_w), .unit_a(unit_a_w), .unit_b(unit_b_w),
    .mul_start(mul_start_w), .mulu_start(mulu_start_w), .div_start(div_start_w), .divu_start(divu_start_w),
    .unit_busy(1'b1), .hi_ena(hi_ena_w), .lo_ena(lo_ena_w),
    .hi_input_signal(hi_sel_w), .lo_input_signal(lo_sel_w),
    .done(done_w), .timeout(timeout_w),
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    .div_zero_exc(div_zero_exc_w),
`endif
    .hilo_read_req(1'b1), .hilo_read_stall(stall_w)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Unit model and per-cycle observation state
  int  busy_len = 0, busy_left = 0;
  bit  start_pend = 0, in_flight = 0;
  int  cyc = 0;
  int  n_mul, n_mulu, n_div, n_divu, n_done, n_hi, n_lo, n_to, n_exc, ready_bad, stall_bad;
  int  last_start_cyc, last_done_cyc;
  logic [1:0] hi_sel_done, lo_sel_done;

  task automatic clr_stats();
    n_mul = 0; n_mulu = 0; n_div = 0; n_divu = 0; n_done = 0; n_hi = 0; n_lo = 0;
    n_to = 0; n_exc = 0; ready_bad = 0; stall_bad = 0;
    last_start_cyc = -1; last_done_cyc = -1; hi_sel_done = 2'bxx; lo_sel_done = 2'bxx;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (start_pend) begin busy_left = busy_len; start_pend = 0; end
    unit_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    #1;
    cyc++;
    if (mul_start)  n_mul++;
    if (mulu_start) n_mulu++;
    if (div_start)  n_div++;
    if (divu_start) n_divu++;
    if (mul_start || mulu_start || div_start || divu_start) begin
      start_pend = 1; last_start_cyc = cyc;
    end
    if (hi_ena) n_hi++;
    if (lo_ena) n_lo++;
    if (timeout) n_to++;
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    if (div_zero_exc) n_exc++;
`endif
    if (done) begin
      n_done++; last_done_cyc = cyc; hi_sel_done = hi_input_signal; lo_sel_done = lo_input_signal;
    end
    if (in_flight && op_ready) ready_bad++;
    if (in_flight && hilo_read_req && !hilo_read_stall) stall_bad++;
    if (done || timeout) in_flight = 0;
  endtask

  task automatic issue(input logic [1:0] code, input logic [31:0] rs, input logic [31:0] rt, input int len);
    int g = 0;
    while (!op_ready && g < 100) begin step(); g++; end
    busy_len = len; op_code = code; op_rs = rs; op_rt = rt; op_valid = 1'b1;
    in_flight = 1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_end();
    int g = 0;
    bit ok = 0;
    while (g < 200 && !ok) begin
      step(); g++;
      if (done || timeout) ok = 1;
    end
    if (!ok) chk("end_bound", 32'd0, 32'd1);
  endtask

  initial begin
    int first_done, ready_after_done, to_cyc, to_cnt, st_w, hi_w, dn_w, rdy_after;

    // Reset state
    clr_stats();
    step(); step();
    chk("rst_op_ready", op_ready, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_done", done, 0);
    chk("rst_hi_ena", hi_ena, 0);
    chk("rst_sel", hi_input_signal, 2'b00);
    rst = 1'b1;
    step();
    chk("idle_op_ready", op_ready, 1);

    // MULT 3*5, busy 3 cycles
    clr_stats();
    issue(2'b00, 32'd3, 32'd5, 3);
    wait_end();
    chk("mult_starts", n_mul, 1);
    chk("mult_other_starts", n_mulu + n_div + n_divu, 0);
    chk("mult_done", n_done, 1);
    chk("mult_hi_lo", n_hi + n_lo, 2);
    chk("mult_hi_sel", hi_sel_done, 2'b00);
    chk("mult_lo_sel", lo_sel_done, 2'b00);
    chk("mult_latency", last_done_cyc - last_start_cyc, 5);
    chk("mult_ready_low", ready_bad, 0);
    chk("mult_unit_a", unit_a, 3);
    chk("mult_unit_b", unit_b, 5);
    step();
    chk("mult_ready_after", op_ready, 1);

    // Busy never rises: first WAIT cycle ignores busy, minimum latency
    clr_stats();
    issue(2'b00, 32'd2, 32'd2, 0);
    wait_end();
    chk("min_latency", last_done_cyc - last_start_cyc, 3);

    // DIVU 100/7, busy 32 cycles, MFHI/MFLO pending throughout
    clr_stats();
    hilo_read_req = 1'b1;
    issue(2'b11, 32'd100, 32'd7, 32);
    wait_end();
    chk("divu_starts", n_divu, 1);
    chk("divu_other_starts", n_mul + n_mulu + n_div, 0);
    chk("divu_done", n_done, 1);
    chk("divu_sel", hi_sel_done, 2'b10);
    chk("divu_latency", last_done_cyc - last_start_cyc, 34);
    chk("divu_stall_held", stall_bad, 0);
    chk("divu_timeout", n_to, 0);
    step();
    chk("divu_stall_idle", hilo_read_stall, 0);
    hilo_read_req = 1'b0;

    // Back-to-back: op_valid held through a MULTU completion
    clr_stats();
    issue(2'b01, 32'd7, 32'd9, 2);
    op_valid = 1'b1; op_rs = 32'd11; op_rt = 32'd13;
    wait_end();
    first_done = last_done_cyc;
    step();
    ready_after_done = op_ready;
    in_flight = 1;
    step();
    op_valid = 1'b0;
    chk("b2b_ready_after_done", ready_after_done, 1);
    chk("b2b_start_gap", last_start_cyc - first_done, 2);
    wait_end();
    chk("b2b_starts", n_mulu, 2);
    chk("b2b_done", n_done, 2);
    chk("b2b_sel", hi_sel_done, 2'b11);
    chk("b2b_unit_a", unit_a, 11);
    repeat (8) step();
    chk("b2b_no_third", n_mulu, 2);

    // Reset in the middle of WAIT
    clr_stats();
    hilo_read_req = 1'b1;
    issue(2'b10, 32'd50, 32'd5, 20);
    repeat (4) step();
    rst = 1'b0; in_flight = 0;
    step();
    chk("mrst_op_ready", op_ready, 0);
    chk("mrst_outs", {hi_ena, lo_ena, done, timeout, mul_start, mulu_start, div_start, divu_start}, 0);
    chk("mrst_stall", hilo_read_stall, 0);
    chk("mrst_unit_a", unit_a, 0);
    step();
    rst = 1'b1;
    step();
    chk("mrst_ready", op_ready, 1);
    repeat (30) step();
    chk("mrst_no_done", n_done + n_hi, 0);
    hilo_read_req = 1'b0;

    // DIV by zero
    clr_stats();
    issue(2'b10, 32'd9, 32'd0, 2);
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    in_flight = 0;
    repeat (6) step();
    chk("dz_exc", n_exc, 1);
    chk("dz_no_start", n_div, 0);
    chk("dz_no_write", n_hi + n_lo + n_done, 0);
`else
    wait_end();
    chk("dz_div_start", n_div, 1);
    chk("dz_done", n_done, 1);
    chk("dz_sel", hi_sel_done, 2'b01);
`endif

    // Watchdog with MAX_CYCLES=8 and busy stuck high
    to_cyc = 0; to_cnt = 0; st_w = 0; hi_w = 0; dn_w = 0; rdy_after = -1;
    @(posedge clk); #2;
    chk("wd_idle_ready", op_ready_w, 1);
    op_valid_w = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #2;
      op_valid_w = 1'b0;
      if (mul_start_w) st_w++;
      if (hi_ena_w || lo_ena_w) hi_w++;
      if (done_w) dn_w++;
      if (to_cyc != 0 && i == to_cyc + 1) rdy_after = op_ready_w;
      if (timeout_w) begin to_cnt++; if (to_cyc == 0) to_cyc = i; end
    end
    chk("wd_timeout_cycle", to_cyc, 9);
    chk("wd_timeout_pulses", to_cnt, 1);
    chk("wd_starts", st_w, 1);
    chk("wd_no_write", hi_w + dn_w, 0);
    chk("wd_ready_after", rdy_after, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
